// File: rtl/riscvvec_dmem_width_adapter.sv
// Bridges the vector core's wide data-memory port onto a narrow single-port memory:
// each wide request becomes up to eight sequential narrow beats, gathered into one wide response.
module riscvvec_dmem_width_adapter #(
  parameter int p_addr_sz   = 32,
  parameter int p_wide_sz   = 256,
  parameter int p_narrow_sz = 32,
  localparam int c_wlen     = $clog2(p_wide_sz / 8),
  localparam int c_nlen     = $clog2(p_narrow_sz / 8),
  localparam int c_beats    = p_wide_sz / p_narrow_sz,
  localparam int c_kw       = $clog2(c_beats),
  localparam int c_wreq_sz  = 1 + p_addr_sz + c_wlen + p_wide_sz,
  localparam int c_wresp_sz = 1 + c_wlen + p_wide_sz,
  localparam int c_nreq_sz  = 1 + p_addr_sz + c_nlen + p_narrow_sz,
  localparam int c_nresp_sz = 1 + c_nlen + p_narrow_sz
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [c_wreq_sz-1:0]  wreq_msg,
  input  logic                  wreq_val,
  output logic                  wreq_rdy,
  output logic [c_wresp_sz-1:0] wresp_msg,
  output logic                  wresp_val,
  input  logic                  wresp_rdy,
  output logic [c_nreq_sz-1:0]  nreq_msg,
  output logic                  nreq_val,
  input  logic                  nreq_rdy,
  input  logic [c_nresp_sz-1:0] nresp_msg,
  input  logic                  nresp_val,
  output logic                  nresp_rdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [c_kw-1:0]        k;
  logic [c_kw-1:0]        last_k;
  logic                   typ;
  logic [p_addr_sz-1:0]   addr;
  logic [c_wlen-1:0]      len;
  logic [p_wide_sz-1:0]   wdata;
  logic [p_wide_sz-1:0]   buffer;

  logic                   in_typ;
  logic [p_addr_sz-1:0]   in_addr;
  logic [c_wlen-1:0]      in_len;
  logic [p_wide_sz-1:0]   in_data;
  logic [c_kw-1:0]        in_last_k;

  logic [p_addr_sz-1:0]   beat_addr;
  logic [c_nlen-1:0]      beat_len;
  logic [p_narrow_sz-1:0] beat_data;
  logic                   unused_nresp_hdr;

  assign {in_typ, in_addr, in_len, in_data} = wreq_msg;

  // The narrow response header carries nothing the adapter needs.
  assign unused_nresp_hdr = ^nresp_msg[c_nresp_sz-1:p_narrow_sz];

  // Index of the final beat: ceil(len/4)-1, or the last lane for a full-width access.
  always_comb begin
    in_last_k = c_kw'(c_beats - 1);
    if (in_len != '0) begin
      in_last_k = c_kw'((in_len - 1'b1) >> c_nlen);
    end
  end

  assign beat_addr = addr + (p_addr_sz'(k) << c_nlen);
  assign beat_len  = (k == last_k && len != '0) ? len[c_nlen-1:0] : '0;
  assign beat_data = typ ? wdata[int'(k)*p_narrow_sz +: p_narrow_sz] : '0;

  assign nreq_msg  = nreq_val  ? {typ, beat_addr, beat_len, beat_data} : '0;
  assign wresp_msg = wresp_val ? {typ, len, buffer} : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      last_k    <= '0;
      typ       <= 1'b0;
      addr      <= '0;
      len       <= '0;
      wdata     <= '0;
      buffer    <= '0;
      wreq_rdy  <= 1'b0;
      nreq_val  <= 1'b0;
      nresp_rdy <= 1'b0;
      wresp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wreq_rdy <= 1'b1;
          if (wreq_val && wreq_rdy) begin
            typ      <= in_typ;
            addr     <= in_addr;
            len      <= in_len;
            wdata    <= in_data;
            k        <= '0;
            last_k   <= in_last_k;
            buffer   <= '0;
            wreq_rdy <= 1'b0;
            nreq_val <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (nreq_val && nreq_rdy) begin
            nreq_val  <= 1'b0;
            nresp_rdy <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (nresp_val && nresp_rdy) begin
            nresp_rdy <= 1'b0;
            if (!typ) begin
              buffer[int'(k)*p_narrow_sz +: p_narrow_sz] <= nresp_msg[p_narrow_sz-1:0];
            end
            if (k == last_k) begin
              wresp_val <= 1'b1;
              state     <= RESP;
            end else begin
              k        <= k + 1'b1;
              nreq_val <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        RESP: begin
          if (wresp_val && wresp_rdy) begin
            wresp_val <= 1'b0;
            wreq_rdy  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscvvec_dmem_width_adapter.sv
// Directed bench for the wide-to-narrow data-memory adapter, with a one-cycle
// 32-bit memory model that can hold off requests on a chosen beat.
module tb_riscvvec_dmem_width_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic [293:0] wreq_msg;
  logic         wreq_val;
  logic         wreq_rdy;
  logic [261:0] wresp_msg;
  logic         wresp_val;
  logic         wresp_rdy;
  logic [66:0]  nreq_msg;
  logic         nreq_val;
  logic         nreq_rdy;
  logic [34:0]  nresp_msg;
  logic         nresp_val;
  logic         nresp_rdy;

  riscvvec_dmem_width_adapter dut (
    .clk       (clk),
    .reset     (reset),
    .wreq_msg  (wreq_msg),
    .wreq_val  (wreq_val),
    .wreq_rdy  (wreq_rdy),
    .wresp_msg (wresp_msg),
    .wresp_val (wresp_val),
    .wresp_rdy (wresp_rdy),
    .nreq_msg  (nreq_msg),
    .nreq_val  (nreq_val),
    .nreq_rdy  (nreq_rdy),
    .nresp_msg (nresp_msg),
    .nresp_val (nresp_val),
    .nresp_rdy (nresp_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Edge bookkeeping: cyc labels each rising edge, wfire_edge is the label of the last wide accept.
  int cyc = 0;
  int wfire_cnt = 0;
  int wfire_edge = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wreq_val && wreq_rdy) begin
      wfire_cnt  <= wfire_cnt + 1;
      wfire_edge <= cyc + 1;
    end
  end

  logic [31:0] mem [logic [31:0]];
  logic [66:0] nreq_log [$];
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_cnt = 0;
  logic [66:0] stall_first;
  logic [66:0] stall_last;
  bit          have_resp = 1'b0;
  bit          drop_resp = 1'b0;
  logic [31:0] resp_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
  endfunction

  function automatic logic [255:0] exp_rd(input logic [31:0] a, input int beats);
    logic [255:0] r = '0;
    for (int i = 0; i < beats; i++) r[i*32 +: 32] = mem_rd(a + 32'(4 * i));
    return r;
  endfunction

  function automatic logic [293:0] wmsg(input logic t, input logic [31:0] a,
                                        input logic [4:0] l, input logic [255:0] d);
    return {t, a, l, d};
  endfunction

  // Memory decides everything on the falling edge for the rising edge that follows.
  initial begin : mem_model
    nreq_rdy  = 1'b1;
    nresp_val = 1'b0;
    nresp_msg = '0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      if (drop_resp) have_resp = 1'b0;
      nresp_val = have_resp;
      nresp_msg = have_resp ? {3'b000, resp_data} : 35'd0;
      if (nresp_val && nresp_rdy) have_resp = 1'b0;
      if (nreq_val && nreq_log.size() == stall_at && stall_cnt < stall_len) begin
        nreq_rdy = 1'b0;
        stall_cnt++;
        if (stall_cnt == 1) stall_first = nreq_msg;
        stall_last = nreq_msg;
      end else begin
        nreq_rdy = 1'b1;
      end
      if (nreq_val && nreq_rdy) begin
        nreq_log.push_back(nreq_msg);
        if (nreq_msg[66]) begin
          mem[nreq_msg[65:34]] = nreq_msg[31:0];
          resp_data = '0;
        end else begin
          resp_data = mem_rd(nreq_msg[65:34]);
        end
        have_resp = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  task automatic issue_wreq(input logic [293:0] msg, input bit keep, input logic [293:0] next,
                            output int t0);
    int n0;
    @(negedge clk);
    wreq_msg = msg;
    wreq_val = 1'b1;
    n0 = wfire_cnt;
    for (int i = 0; i < 100 && wfire_cnt == n0; i++) @(negedge clk);
    if (wfire_cnt == n0) check("wreq_accept_timeout", 300'(0), 300'(1));
    t0 = wfire_edge;
    if (keep) begin
      wreq_msg = next;
    end else begin
      wreq_val = 1'b0;
      wreq_msg = '0;
    end
  endtask

  task automatic collect_wresp(input int stall, output logic [261:0] r_first,
                               output logic [261:0] r_last, output int t_val,
                               output int t_back, output logic rdy_back);
    for (int i = 0; i < 200 && !wresp_val; i++) @(negedge clk);
    if (!wresp_val) check("wresp_timeout", 300'(0), 300'(1));
    t_val   = cyc;
    r_first = wresp_msg;
    for (int i = 0; i < stall; i++) begin
      wresp_rdy = 1'b0;
      @(negedge clk);
    end
    r_last    = wresp_msg;
    wresp_rdy = 1'b1;
    @(negedge clk);
    t_back   = cyc;
    rdy_back = wreq_rdy;
  endtask

  // Cycle numbers count the cycle right after the accepting edge as cycle 1.
  task automatic run_txn(input string tag, input logic [293:0] msg, input int stall,
                         input logic [261:0] exp, input int exp_cyc);
    int t0, tv, tb;
    logic [261:0] r0, r1;
    logic rb;
    issue_wreq(msg, 1'b0, '0, t0);
    collect_wresp(stall, r0, r1, tv, tb, rb);
    check({tag, "_resp"}, 300'(r0), 300'(exp));
    if (stall > 0) check({tag, "_resp_held"}, 300'(r1), 300'(exp));
    check({tag, "_resp_cyc"}, 300'(tv - t0 + 1), 300'(exp_cyc));
    check({tag, "_rdy_back"}, 300'(rb), 300'(1));
    check({tag, "_rdy_cyc"}, 300'(tb - t0 + 1), 300'(exp_cyc + 1 + stall));
  endtask

  task automatic check_beats(input string tag, input int base, input int n, input logic t,
                             input logic [31:0] a, input logic [4:0] len, input logic [255:0] d);
    logic [66:0] exp, got;
    logic [1:0] nl;
    check({tag, "_cnt"}, 300'(nreq_log.size() - base), 300'(n));
    for (int k = 0; k < n; k++) begin
      nl  = (k == n - 1 && len != 5'd0) ? len[1:0] : 2'd0;
      exp = {t, a + 32'(4 * k), nl, t ? d[k*32 +: 32] : 32'd0};
      got = (base + k < nreq_log.size()) ? nreq_log[base + k] : 'x;
      check($sformatf("%s%0d", tag, k), 300'(got), 300'(exp));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [255:0] pat;
    logic [261:0] r1, r1b, r2, r2b;
    int base, t0, t0b, tv, tb, n1;
    logic rb;

    reset     = 1'b0;
    wreq_val  = 1'b0;
    wreq_msg  = '0;
    wresp_rdy = 1'b1;
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);

    repeat (2) @(negedge clk);
    check("rst_vr", 300'({wreq_rdy, nreq_val, nresp_rdy, wresp_val}), 300'(0));
    check("rst_nreq_msg", 300'(nreq_msg), 300'(0));
    check("rst_wresp_msg", 300'(wresp_msg), 300'(0));
    reset = 1'b1;
    @(negedge clk);
    check("idle_rdy", 300'(wreq_rdy), 300'(1));

    // Full-width write, then read it back.
    base = nreq_log.size();
    run_txn("wr", wmsg(1'b1, 32'h2000, 5'd0, pat), 0, {1'b1, 5'd0, 256'd0}, 17);
    check_beats("wr_beat", base, 8, 1'b1, 32'h2000, 5'd0, pat);
    check("wr_lane0", 300'(nreq_log[base][31:0]), 300'(32'h0302_0100));
    check("wr_lane7", 300'(nreq_log[base + 7][31:0]), 300'(32'h1F1E_1D1C));

    base = nreq_log.size();
    run_txn("rd", wmsg(1'b0, 32'h2000, 5'd0, '1), 0, {1'b0, 5'd0, pat}, 17);
    check_beats("rd_beat", base, 8, 1'b0, 32'h2000, 5'd0, '0);

    // Partial read: two beats, final beat length 2, upper lanes zero.
    base = nreq_log.size();
    run_txn("part", wmsg(1'b0, 32'h100, 5'd6, '0), 0,
            {1'b0, 5'd6, 192'd0, mem_rd(32'h104), mem_rd(32'h100)}, 5);
    check_beats("part_beat", base, 2, 1'b0, 32'h100, 5'd6, '0);

    // Backpressure: beat 4 held off three cycles, wide response held off two.
    base      = nreq_log.size();
    stall_at  = base + 4;
    stall_len = 3;
    run_txn("bp", wmsg(1'b0, 32'h2000, 5'd0, '0), 2, {1'b0, 5'd0, pat}, 20);
    check("bp_nreq_first", 300'(stall_first), 300'({1'b0, 32'h2010, 2'd0, 32'd0}));
    check("bp_nreq_last", 300'(stall_last), 300'({1'b0, 32'h2010, 2'd0, 32'd0}));
    check_beats("bp_beat", base, 8, 1'b0, 32'h2000, 5'd0, '0);
    stall_at  = -1;
    stall_len = 0;

    // Reset while waiting on the response to beat 3.
    base = nreq_log.size();
    issue_wreq(wmsg(1'b0, 32'h2000, 5'd0, '0), 1'b0, '0, t0);
    for (int i = 0; i < 40 && nreq_log.size() < base + 4; i++) @(posedge clk);
    if (nreq_log.size() < base + 4) check("rst_mid_beat3_timeout", 300'(0), 300'(1));
    #2;
    check("pre_rst_wait", 300'(nresp_rdy), 300'(1));
    reset = 1'b0;
    #1;
    check("rst_mid_vr", 300'({wreq_rdy, nreq_val, nresp_rdy, wresp_val}), 300'(0));
    check("rst_mid_nreq_msg", 300'(nreq_msg), 300'(0));
    check("rst_mid_wresp_msg", 300'(wresp_msg), 300'(0));
    repeat (2) @(negedge clk);
    check("rst_hold_vr", 300'({wreq_rdy, nreq_val, nresp_rdy, wresp_val}), 300'(0));
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 300'(wreq_rdy), 300'(1));
    check("late_nresp_rdy", 300'(nresp_rdy), 300'(0));
    @(negedge clk);
    check("late_nresp_rdy2", 300'({nresp_rdy, wresp_val, nreq_val}), 300'(0));
    @(posedge clk);
    #2 drop_resp = 1'b1;
    @(posedge clk);
    #2 drop_resp = 1'b0;
    check("rst_no_new_beats", 300'(nreq_log.size() - base), 300'(4));
    run_txn("post_rst", wmsg(1'b0, 32'h2000, 5'd0, '0), 0, {1'b0, 5'd0, pat}, 17);

    // Address wrap with a second request waiting behind it.
    base = nreq_log.size();
    issue_wreq(wmsg(1'b0, 32'hFFFF_FFF0, 5'd0, '0), 1'b1,
               wmsg(1'b1, 32'h300, 5'd8, pat), t0);
    n1 = wfire_cnt;
    collect_wresp(0, r1, r1b, tv, tb, rb);
    check("wrap_resp", 300'(r1), 300'({1'b0, 5'd0, exp_rd(32'hFFFF_FFF0, 8)}));
    check("wrap_resp_cyc", 300'(tv - t0 + 1), 300'(17));
    check_beats("wrap_beat", base, 8, 1'b0, 32'hFFFF_FFF0, 5'd0, '0);
    check("wrap_addr4", 300'(nreq_log[base + 4][65:34]), 300'(32'h0));
    check("wrap_addr7", 300'(nreq_log[base + 7][65:34]), 300'(32'hC));
    for (int i = 0; i < 50 && wfire_cnt == n1; i++) @(negedge clk);
    if (wfire_cnt == n1) check("b2b_accept_timeout", 300'(0), 300'(1));
    t0b      = wfire_edge;
    wreq_val = 1'b0;
    wreq_msg = '0;
    check("b2b_gap", 300'(t0b - t0), 300'(18));
    collect_wresp(0, r2, r2b, tv, tb, rb);
    check("b2b_resp", 300'(r2), 300'({1'b1, 5'd8, 256'd0}));
    check("b2b_resp_cyc", 300'(tv - t0b + 1), 300'(5));
    check_beats("b2b_beat", base + 8, 2, 1'b1, 32'h300, 5'd8, pat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscvvec_dmem_width_adapter.md
# riscvvec_dmem_width_adapter

Responder-side bridge between the vector core's 256-bit data-memory port and a 32-bit single-port memory. It accepts one wide VC memory request at a time, splits it into sequential 32-bit requests to the narrow memory, and gathers the narrow responses into a single wide response. This lets the vector core run against the standard 32-bit test memory, or a future 32-bit cache, without changing the core.

## Interface
Parameters:
- p_addr_sz, 32, address width, identical on both sides
- p_wide_sz, 256, upstream data width; must equal p_narrow_sz × 8
- p_narrow_sz, 32, downstream data width

Message formats, MSB first; len = 0 means full width:
- Wide request (294 b): type[1], addr[32], len[5], data[256]
- Wide response (262 b): type[1], len[5], data[256]
- Narrow request (67 b): type[1], addr[32], len[2], data[32]
- Narrow response (35 b): type[1], len[2], data[32]
- type encoding: 0 = read, 1 = write

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wreq_msg  in  294  wide request from the core
- wreq_val  in  1  wide request valid
- wreq_rdy  out  1  adapter can accept a wide request
- wresp_msg  out  262  wide response to the core
- wresp_val  out  1  wide response valid
- wresp_rdy  in  1  core accepts the wide response
- nreq_msg  out  67  narrow request to memory
- nreq_val  out  1  narrow request valid
- nreq_rdy  in  1  memory accepts the narrow request
- nresp_msg  in  35  narrow response from memory
- nresp_val  in  1  narrow response valid
- nresp_rdy  out  1  adapter accepts the narrow response

## Operation
- Handshake rule: a transfer fires on a rising clk edge where val and rdy are both 1. The sender holds msg stable while val is high and rdy is low.
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset value is IDLE.
- IDLE
  - wreq_rdy = 1.
  - When a wide request fires, latch type, addr, len and data. Set beat counter k = 0 and beat count B. Clear the assembly buffer. Go to ISSUE.
- Beat count B: 8 if len = 0, otherwise ceil(len/4), giving 1..8.
- ISSUE
  - nreq_val = 1.
  - nreq_msg = {type, addr + 4k, nlen, wdata[32k+31:32k]}.
  - Write data is forwarded on writes; the data field is 0 on reads.
  - nlen = len mod 4 on the final beat when len ≠ 0. Otherwise nlen = 0.
  - When the narrow request fires, go to WAIT.
- WAIT
  - nresp_rdy = 1.
  - When a narrow response fires on a read, store nresp data into buffer bits [32k+31:32k].
  - If k = B−1, go to RESP. Otherwise increment k and go to ISSUE.
- RESP
  - wresp_val = 1.
  - wresp_msg = {latched type, latched len, buffer}.
  - Buffer lanes ≥ B are 0. Response data is all zeros for writes.
  - When the wide response fires, go to IDLE.
- Only one narrow request is outstanding at a time. The narrow response type and len are ignored.
- Address arithmetic is modulo 2^32, so wrap-around is allowed.
- All val/rdy outputs not named for the current state are 0.
- While reset is low: FSM is in IDLE, all val/rdy outputs are 0, all msg outputs are 0, k = 0, buffer = 0.
- Reset asserted mid-transfer: the transfer is abandoned immediately and asynchronously, and no wide response is produced. A narrow response still in flight after release is dropped, because nresp_rdy is 0 in IDLE.

## Timing
- The wide request fires at edge 0. Beat k's nreq_val rises in cycle 2k+1, assuming nreq_rdy = 1.
- Each beat's response is accepted no earlier than the cycle after its request fires.
- With one-cycle memory and no backpressure, a full 256-bit access:
  - wresp_val is high in cycle 2B+1 (cycle 17 for B = 8).
  - wreq_rdy returns in cycle 2B+2.
- Each cycle of nreq_rdy low, nresp_val low, or wresp_rdy low extends the access by exactly one cycle. No outputs change during those stall cycles.
- Back-to-back wide requests are separated by at least one IDLE cycle.
- All outputs are decoded from registered state only. No combinational path exists from any input to any output.

## Test plan
- Full-width write then read:
  - Write 256-bit pattern 0x1F1E…0100 to addr 0x2000 with len = 0. Expect 8 narrow writes to addr 0x2000..0x201C carrying 0x03020100..0x1F1E1D1C, and a wide write response with zero data in cycle 17.
  - Then read the same address. Expect wresp data equal to the written pattern, type = 0, len = 0.
- Partial read: len = 6 at addr 0x100. Expect 2 beats, nlen 0 then 2, addrs 0x100 and 0x104. Response lanes 2..7 are zero and wresp len = 6.
- Backpressure: hold nreq_rdy low for 3 cycles on beat 4 and wresp_rdy low for 2 cycles. Expect msgs held stable, completion 5 cycles later than the no-stall case, and correct data.
- Reset mid-transfer: assert reset during the WAIT of beat 3. Expect all val/rdy outputs at 0 immediately. After release, wreq_rdy = 1, a late nresp_val is not accepted, and the next request completes correctly.
- Wrap and back-to-back: a read at addr 0xFFFFFFF0 with len = 0 issues addrs wrapping to 0x0..0xC. A second request presented immediately after is accepted only once wreq_rdy is high again.
